// File: rtl/cut_sched_pkg.sv
// Shared types and widths for the cut job scheduler.
package cut_sched_pkg;

  localparam int PIECE_W = 8;
  localparam int FEED_W  = 12;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FEED = 3'd1,
    CUT  = 3'd2,
    GAP  = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;

endpackage

// File: rtl/step_rate_gen.sv
// Feed step timebase: one-cycle tick every STEP_PERIOD enabled cycles.
module step_rate_gen #(
  parameter int STEP_PERIOD = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (STEP_PERIOD > 1) ? $clog2(STEP_PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_PERIOD - 1);

  logic [CNT_W-1:0] cnt;

  // Disabling restarts the period so every FEED entry sees a full period first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!enable || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/cut_job_scheduler.sv
// Sequences feed-then-cut cycles for a batch of pieces, with cut timeout and abort.
module cut_job_scheduler
  import cut_sched_pkg::*;
#(
  parameter int STEP_PERIOD = 100000,
  parameter int CUT_TIMEOUT = 1000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [PIECE_W-1:0] piece_cnt_i,
  input  logic [FEED_W-1:0]  feed_len_i,
  input  logic               abort_i,
  output logic               feed_step_o,
  output logic               cut_o,
  input  logic               cut_end_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               error_o,
  output logic [PIECE_W-1:0] pieces_done_o
);

  localparam int TO_W = $clog2(CUT_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(CUT_TIMEOUT - 1);

  state_t             state, state_nx;
  logic [PIECE_W-1:0] piece_cnt_q;
  logic [FEED_W-1:0]  feed_len_q;
  logic [FEED_W-1:0]  step_cnt;
  logic [TO_W-1:0]    to_cnt;
  logic [PIECE_W-1:0] pieces_done;
  logic               tick;

  step_rate_gen #(
    .STEP_PERIOD(STEP_PERIOD)
  ) u_step_rate_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .enable(state == FEED),
    .tick  (tick)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start_i) begin
          if (piece_cnt_i == '0)     state_nx = DONE;
          else if (feed_len_i == '0) state_nx = CUT;
          else                       state_nx = FEED;
        end
      end
      FEED: if (tick && (step_cnt + FEED_W'(1)) == feed_len_q) state_nx = CUT;
      CUT: begin
        if (cut_end_i)              state_nx = GAP;
        else if (to_cnt == TO_LAST) state_nx = ERR;
      end
      GAP: begin
        if (pieces_done == piece_cnt_q) state_nx = DONE;
        else if (feed_len_q == '0)      state_nx = CUT;
        else                            state_nx = FEED;
      end
      DONE:    state_nx = IDLE;
      ERR:     state_nx = ERR;
      default: state_nx = IDLE;
    endcase
    // Abort overrides every other transition, including the final cut_end.
    if (abort_i) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      step_cnt    <= '0;
      to_cnt      <= '0;
      pieces_done <= '0;
    end else begin
      state <= state_nx;

      if (state != FEED)  step_cnt <= '0;
      else if (tick)      step_cnt <= step_cnt + 1'b1;

      if (state != CUT)   to_cnt <= '0;
      else                to_cnt <= to_cnt + 1'b1;

      if (!abort_i) begin
        if (state == IDLE && start_i) begin
          pieces_done <= '0;
        end else if (state == CUT && cut_end_i && pieces_done < piece_cnt_q) begin
          pieces_done <= pieces_done + PIECE_W'(1);
        end
      end
    end
  end

  // Job parameters only matter once a job is accepted, so they carry no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && start_i && !abort_i) begin
      piece_cnt_q <= piece_cnt_i;
      feed_len_q  <= feed_len_i;
    end
  end

  assign feed_step_o   = tick && !abort_i;
  assign cut_o         = (state == CUT) && !abort_i;
  assign busy_o        = (state == FEED) || (state == CUT) || (state == GAP);
  assign done_o        = (state == DONE) && !abort_i;
  assign error_o       = (state == ERR);
  assign pieces_done_o = pieces_done;

endmodule

// File: tb/tb_cut_job_scheduler.sv
// Directed self-checking bench for cut_job_scheduler (STEP_PERIOD=4, CUT_TIMEOUT=50).
module tb_cut_job_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [7:0]  piece_cnt_i;
  logic [11:0] feed_len_i;
  logic        abort_i;
  logic        feed_step_o;
  logic        cut_o;
  logic        cut_end_i;
  logic        busy_o;
  logic        done_o;
  logic        error_o;
  logic [7:0]  pieces_done_o;

  int checks = 0;
  int failures = 0;

  cut_job_scheduler #(
    .STEP_PERIOD(4),
    .CUT_TIMEOUT(50)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .piece_cnt_i  (piece_cnt_i),
    .feed_len_i   (feed_len_i),
    .abort_i      (abort_i),
    .feed_step_o  (feed_step_o),
    .cut_o        (cut_o),
    .cut_end_i    (cut_end_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .error_o      (error_o),
    .pieces_done_o(pieces_done_o)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packs the five control outputs as {feed_step, cut, done, busy, error}.
  function automatic logic [31:0] outs();
    return {27'd0, feed_step_o, cut_o, done_o, busy_o, error_o};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] exp_v;
    rst_n = 1'b0; start_i = 1'b0; piece_cnt_i = '0; feed_len_i = '0;
    abort_i = 1'b0; cut_end_i = 1'b0;
    cyc(3);
    chk("reset_outs", outs(), 32'h0);
    chk("reset_pieces", {24'd0, pieces_done_o}, 32'd0);
    rst_n = 1'b1;
    cyc(2);
    chk("idle_outs", outs(), 32'h0);

    // Two pieces, three feed steps each; cut_end 5 cycles after each cut rise.
    start_i = 1'b1; piece_cnt_i = 8'd2; feed_len_i = 12'd3;
    cyc(1);
    start_i = 1'b0;
    for (int c = 0; c < 46; c++) begin
      cut_end_i = (c == 17 || c == 36);
      exp_v = '0;
      exp_v[4] = (c == 3 || c == 7 || c == 11 || c == 22 || c == 26 || c == 30);
      exp_v[3] = (c >= 12 && c <= 17) || (c >= 31 && c <= 36);
      exp_v[2] = (c == 38);
      exp_v[1] = (c <= 37);
      chk($sformatf("job2x3_c%0d", c), outs(), exp_v);
      if (c == 18) chk("job2x3_pieces_mid", {24'd0, pieces_done_o}, 32'd1);
      cyc(1);
    end
    cut_end_i = 1'b0;
    chk("job2x3_pieces_end", {24'd0, pieces_done_o}, 32'd2);

    // Zero-piece job: done next cycle, no motion.
    start_i = 1'b1; piece_cnt_i = 8'd0; feed_len_i = 12'd7;
    cyc(1);
    start_i = 1'b0;
    chk("zero_job_done", outs(), 32'b00110 & 32'b00100);
    cyc(1);
    chk("zero_job_after", outs(), 32'h0);

    // Zero feed length: cut starts immediately.
    start_i = 1'b1; piece_cnt_i = 8'd1; feed_len_i = 12'd0;
    cyc(1);
    start_i = 1'b0;
    chk("nofeed_cut", outs(), 32'b01010);
    cut_end_i = 1'b1;
    cyc(1);
    cut_end_i = 1'b0;
    chk("nofeed_gap", outs(), 32'b00010);
    chk("nofeed_pieces", {24'd0, pieces_done_o}, 32'd1);
    cyc(1);
    chk("nofeed_done", outs(), 32'b00100);
    cyc(1);
    chk("nofeed_idle", outs(), 32'h0);

    // Cut timeout after 50 CUT cycles, then abort clears the error.
    start_i = 1'b1; piece_cnt_i = 8'd1; feed_len_i = 12'd0;
    cyc(1);
    start_i = 1'b0;
    for (int c = 0; c < 50; c++) begin
      chk($sformatf("timeout_cut_c%0d", c), outs(), 32'b01010);
      cyc(1);
    end
    chk("timeout_err", outs(), 32'b00001);
    cut_end_i = 1'b1; start_i = 1'b1;
    cyc(2);
    cut_end_i = 1'b0; start_i = 1'b0;
    chk("err_sticky", outs(), 32'b00001);
    chk("err_pieces", {24'd0, pieces_done_o}, 32'd0);
    abort_i = 1'b1;
    cyc(1);
    abort_i = 1'b0;
    chk("err_cleared", outs(), 32'h0);
    cyc(1);
    chk("err_idle", outs(), 32'h0);

    // Abort coincident with the final cut_end.
    start_i = 1'b1; piece_cnt_i = 8'd2; feed_len_i = 12'd0;
    cyc(1);
    start_i = 1'b0;
    cut_end_i = 1'b1;
    cyc(1);
    cut_end_i = 1'b0;
    chk("abort_gap1", {24'd0, pieces_done_o}, 32'd1);
    cyc(1);
    chk("abort_cut2", outs(), 32'b01010);
    cut_end_i = 1'b1; abort_i = 1'b1;
    #1;
    chk("abort_cut_gated", {31'd0, cut_o}, 32'd0);
    cyc(1);
    cut_end_i = 1'b0; abort_i = 1'b0;
    chk("abort_idle", outs(), 32'h0);
    chk("abort_pieces", {24'd0, pieces_done_o}, 32'd1);
    cyc(1);
    chk("abort_no_done", outs(), 32'h0);

    // Restart ignored while busy, then reset mid-FEED.
    start_i = 1'b1; piece_cnt_i = 8'd2; feed_len_i = 12'd1;
    cyc(1);
    piece_cnt_i = 8'd0; feed_len_i = 12'd0;
    cyc(1);
    chk("restart_ignored1", outs(), 32'b00010);
    cyc(1);
    start_i = 1'b0;
    chk("restart_ignored2", outs(), 32'b00010);
    cyc(1);
    chk("rst_job_step", outs(), 32'b10010);
    cyc(1);
    chk("rst_job_cut", outs(), 32'b01010);
    cut_end_i = 1'b1;
    cyc(1);
    cut_end_i = 1'b0;
    chk("rst_job_pieces", {24'd0, pieces_done_o}, 32'd1);
    cyc(1);
    chk("rst_job_feed2", outs(), 32'b00010);
    rst_n = 1'b0;
    #1;
    chk("rst_async_outs", outs(), 32'h0);
    chk("rst_async_pieces", {24'd0, pieces_done_o}, 32'd0);
    cyc(2);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      cyc(1);
      chk($sformatf("rst_release_c%0d", c), outs(), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
